seg7_scan_controller: RTL

//   Time-multiplexes four hex digits onto the shared 7-segment bus (seg/dp) and

---
 rtl/seg7_scan_controller.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_controller.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_controller
//  Description : Four-digit multiplexed hex display driver. It drives a shared
//                active-low segment bus and four active-low anodes. Each digit
//                gets a fixed-length slot that starts with a short blanking gap
//                to prevent ghosting. New values are taken through a
//                valid/ready port and become visible only at frame boundaries.
//  Revision    : 1.0  initial release
// ============================================================================
module seg7_scan_controller #(
    parameter int DIV_WIDTH    = 11,   // slot length is 2**DIV_WIDTH cycles
    parameter int BLANK_CYCLES = 16    // dark cycles at the start of each slot
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] data_in,
    input  logic [3:0]  dp_in,
    input  logic        data_valid,
    output logic        data_ready,
    input  logic        blank_zero,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // Last blanking count before a slot starts showing its digit. It always
    // fits in DIV_WIDTH bits because the blanking gap is shorter than a slot.
    localparam logic [DIV_WIDTH-1:0] c_BLANK_LAST = DIV_WIDTH'(BLANK_CYCLES - 1);
    localparam logic [6:0]           c_SEG_OFF    = 7'b1111111;
    localparam logic [3:0]           c_AN_OFF     = 4'b1111;

    // Scan state: explicit one-bit encoding.
    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Segment decoder, gfedcba, active-low
    // ------------------------------------------------------------------------
    function automatic logic [6:0] seg7_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic [DIV_WIDTH-1:0] r_div_cnt;
    logic                 w_tick;
    logic                 w_boundary;

    state_t               r_state;
    state_t               w_state_next;
    logic [DIV_WIDTH-1:0] r_blank_cnt;
    logic [DIV_WIDTH-1:0] w_blank_cnt_next;
    logic [1:0]           r_digit_idx;
    logic [1:0]           w_digit_idx_next;

    logic [15:0]          r_pend_data;
    logic [3:0]           r_pend_dp;
    logic                 r_pend_full;
    logic [15:0]          r_disp_data;
    logic [3:0]           r_disp_dp;
    logic                 w_accept;

    logic [3:0]           w_nib_zero;
    logic [3:0]           w_dark;
    logic [3:0]           w_cur_nib;
    logic                 w_cur_dp;

    logic [3:0]           w_an_next;
    logic [6:0]           w_seg_next;
    logic                 w_dp_next;

    logic [3:0]           r_an;
    logic [6:0]           r_seg;
    logic                 r_dp;
    logic                 r_frame_done;

    // ------------------------------------------------------------------------
    // Slot timing
    // ------------------------------------------------------------------------
    // Free-running slot divider; its all-ones value marks the last cycle of a slot.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_WIDTH'(1);
        end
    end

    assign w_tick     = &r_div_cnt;
    // The last cycle of the digit-3 slot closes a frame.
    assign w_boundary = w_tick && (r_digit_idx == 2'd3);

    // ------------------------------------------------------------------------
    // Scan FSM
    // ------------------------------------------------------------------------
    // Scan state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_BLANK;
            r_blank_cnt <= '0;
            r_digit_idx <= 2'd0;
        end else begin
            r_state     <= w_state_next;
            r_blank_cnt <= w_blank_cnt_next;
            r_digit_idx <= w_digit_idx_next;
        end
    end

    // Next scan state. The end of a slot overrides the blanking count so
    // that every digit change always re-enters the blanking gap.
    always_comb begin
        w_state_next     = r_state;
        w_blank_cnt_next = r_blank_cnt;
        w_digit_idx_next = r_digit_idx;
        if (w_tick) begin
            w_state_next     = ST_BLANK;
            w_blank_cnt_next = '0;
            w_digit_idx_next = r_digit_idx + 2'd1;
        end else begin
            case (r_state)
                ST_BLANK: begin
                    if (r_blank_cnt == c_BLANK_LAST) begin
                        w_state_next = ST_SHOW;
                    end else begin
                        w_blank_cnt_next = r_blank_cnt + DIV_WIDTH'(1);
                    end
                end
                ST_SHOW: begin
                    w_state_next = ST_SHOW;
                end
                default: begin
                    w_state_next = ST_BLANK;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Load port and display buffers
    // ------------------------------------------------------------------------
    assign data_ready = ~r_pend_full;
    assign w_accept   = data_valid && ~r_pend_full;

    // Pending buffer feeds the display only at a frame boundary. A value
    // accepted on the boundary cycle itself lands in pending and waits for
    // the next boundary. The two cases cannot coincide because acceptance
    // requires pending to be empty.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pend_data <= 16'h0000;
            r_pend_dp   <= 4'b0000;
            r_pend_full <= 1'b0;
            r_disp_data <= 16'h0000;
            r_disp_dp   <= 4'b0000;
        end else if (w_boundary && r_pend_full) begin
            r_disp_data <= r_pend_data;
            r_disp_dp   <= r_pend_dp;
            r_pend_full <= 1'b0;
        end else if (w_accept) begin
            r_pend_data <= data_in;
            r_pend_dp   <= dp_in;
            r_pend_full <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Leading-zero suppression
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < 4; gi++) begin : g_nib_zero
        assign w_nib_zero[gi] = (r_disp_data[4*gi +: 4] == 4'h0);
    end

    // A digit goes dark only when it and every digit to its left are zero.
    // Digit 0 is always shown so a zero value still displays "0".
    assign w_dark[3] = blank_zero & w_nib_zero[3];
    assign w_dark[2] = w_dark[3]  & w_nib_zero[2];
    assign w_dark[1] = w_dark[2]  & w_nib_zero[1];
    assign w_dark[0] = 1'b0;

    assign w_cur_nib = r_disp_data[{r_digit_idx, 2'b00} +: 4];
    assign w_cur_dp  = r_disp_dp[r_digit_idx];

    // ------------------------------------------------------------------------
    // Display outputs
    // ------------------------------------------------------------------------
    // Output values for the current scan state; everything is off unless a
    // visible digit is in its show phase.
    always_comb begin
        w_an_next  = c_AN_OFF;
        w_seg_next = c_SEG_OFF;
        w_dp_next  = 1'b1;
        if ((r_state == ST_SHOW) && !w_dark[r_digit_idx]) begin
            w_an_next  = ~(4'b0001 << r_digit_idx);
            w_seg_next = seg7_decode(w_cur_nib);
            w_dp_next  = ~w_cur_dp;
        end
    end

    // Register the pad-facing outputs so they change glitch-free.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_an         <= c_AN_OFF;
            r_seg        <= c_SEG_OFF;
            r_dp         <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_an         <= w_an_next;
            r_seg        <= w_seg_next;
            r_dp         <= w_dp_next;
            r_frame_done <= w_boundary;
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire
